// File: rtl/pool_layer_controller.sv
// Max-pooling layer sequencer: walks feature/row-group/column counters,
// drives the pool window buffer through a cmd/ack handshake, and tags each
// pooled result after the fixed two-cycle comparator latency.
module pool_layer_controller #(
  parameter int POOL_SIZE     = 2,
  parameter int FMAP_SIZE     = 6,
  parameter int OUT_SIZE      = 3,
  parameter int TOTAL_FEATURE = 4,
  parameter int FEAT_WIDTH    = 2,
  parameter int POS_WIDTH     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            pool_ack,
  output logic [1:0]            pool_cmd,
  output logic                  out_valid,
  output logic [FEAT_WIDTH-1:0] out_feature,
  output logic [POS_WIDTH-1:0]  out_row,
  output logic [POS_WIDTH-1:0]  out_col,
  output logic                  layer_done,
  output logic                  busy
);

  localparam logic [1:0] CMD_IDLE      = 2'b00;
  localparam logic [1:0] CMD_LOAD      = 2'b01;
  localparam logic [1:0] CMD_SHIFT     = 2'b10;
  localparam logic [1:0] ACK_LOAD_FIN  = 2'b01;
  localparam logic [1:0] ACK_SHIFT_FIN = 2'b10;

  localparam logic [POS_WIDTH-1:0]  LOAD_LAST = POS_WIDTH'(POOL_SIZE - 1);
  localparam logic [POS_WIDTH-1:0]  POS_LAST  = POS_WIDTH'(OUT_SIZE - 1);
  localparam logic [FEAT_WIDTH-1:0] FEAT_LAST = FEAT_WIDTH'(TOTAL_FEATURE - 1);

  // The pooled grid must tile the feature map exactly.
  generate
    if (FMAP_SIZE != OUT_SIZE * POOL_SIZE) begin : g_size_check
      $error("FMAP_SIZE must equal OUT_SIZE * POOL_SIZE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t                state, state_n;
  logic [POS_WIDTH-1:0]  load_cnt, load_n;
  logic [POS_WIDTH-1:0]  col_cnt, col_n;
  logic [POS_WIDTH-1:0]  row_cnt, row_n;
  logic [FEAT_WIDTH-1:0] feat_cnt, feat_n;
  logic [1:0]            cmd_n;
  logic                  capture;

  logic                  vld_p0, vld_p1;
  logic [FEAT_WIDTH-1:0] feat_p0, feat_p1;
  logic [POS_WIDTH-1:0]  row_p0, row_p1;
  logic [POS_WIDTH-1:0]  col_p0, col_p1;
  logic                  last_p1;

  assign busy    = (state == S_LOAD) || (state == S_SHIFT);
  assign last_p1 = (feat_p1 == FEAT_LAST) && (row_p1 == POS_LAST) && (col_p1 == POS_LAST);

  // Next-state, counter and command decode; dropping enable wins over any ack.
  always_comb begin
    state_n = state;
    load_n  = load_cnt;
    col_n   = col_cnt;
    row_n   = row_cnt;
    feat_n  = feat_cnt;
    cmd_n   = CMD_IDLE;
    capture = 1'b0;
    if (!enable) begin
      state_n = S_IDLE;
      load_n  = '0;
      col_n   = '0;
      row_n   = '0;
      feat_n  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_n = S_LOAD;
          cmd_n   = CMD_LOAD;
        end
        S_LOAD: begin
          if (pool_ack == ACK_LOAD_FIN) begin
            if (load_cnt != LOAD_LAST) begin
              load_n = load_cnt + POS_WIDTH'(1);
              cmd_n  = CMD_LOAD;
            end else begin
              load_n  = '0;
              state_n = S_SHIFT;
              cmd_n   = CMD_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          if (pool_ack == ACK_SHIFT_FIN) begin
            capture = 1'b1;
            if (col_cnt != POS_LAST) begin
              col_n = col_cnt + POS_WIDTH'(1);
              cmd_n = CMD_SHIFT;
            end else if (row_cnt != POS_LAST) begin
              col_n   = '0;
              row_n   = row_cnt + POS_WIDTH'(1);
              state_n = S_LOAD;
              cmd_n   = CMD_LOAD;
            end else if (feat_cnt != FEAT_LAST) begin
              col_n   = '0;
              row_n   = '0;
              feat_n  = feat_cnt + FEAT_WIDTH'(1);
              state_n = S_LOAD;
              cmd_n   = CMD_LOAD;
            end else begin
              col_n   = '0;
              row_n   = '0;
              feat_n  = '0;
              state_n = S_DONE;
            end
          end
        end
        S_DONE: begin
          state_n = S_DONE;
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered command pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      load_cnt <= '0;
      col_cnt  <= '0;
      row_cnt  <= '0;
      feat_cnt <= '0;
      pool_cmd <= CMD_IDLE;
    end else begin
      state    <= state_n;
      load_cnt <= load_n;
      col_cnt  <= col_n;
      row_cnt  <= row_n;
      feat_cnt <= feat_n;
      pool_cmd <= cmd_n;
    end
  end

  // Valid chain; abort and reset flush every stage so nothing partial escapes.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      out_valid  <= 1'b0;
      layer_done <= 1'b0;
    end else begin
      vld_p0     <= capture;
      vld_p1     <= vld_p0;
      out_valid  <= vld_p1;
      layer_done <= vld_p1 && last_p1;
    end
  end

  // ---- stage p0: tag capture at the accepted shift ack ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      feat_p0 <= '0;
      row_p0  <= '0;
      col_p0  <= '0;
    end else if (capture) begin
      feat_p0 <= feat_cnt;
      row_p0  <= row_cnt;
      col_p0  <= col_cnt;
    end
  end

  // ---- stage p1: comparator latency slot ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      feat_p1 <= '0;
      row_p1  <= '0;
      col_p1  <= '0;
    end else if (vld_p0) begin
      feat_p1 <= feat_p0;
      row_p1  <= row_p0;
      col_p1  <= col_p0;
    end
  end

  // ---- stage p2: output tags, held between results and across abort ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_feature <= '0;
      out_row     <= '0;
      out_col     <= '0;
    end else if (vld_p1 && enable) begin
      out_feature <= feat_p1;
      out_row     <= row_p1;
      out_col     <= col_p1;
    end
  end

endmodule

// File: tb/tb_pool_layer_controller.sv
// Self-checking bench for pool_layer_controller: randomized-latency responder
// with spurious acks, and a scoreboard of expected commands and tagged results.
module tb_pool_layer_controller;

  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_SHIFT = 2'b10;
  localparam logic [1:0] ACK_LOAD  = 2'b01;
  localparam logic [1:0] ACK_SHIFT = 2'b10;
  localparam int NF = 4;
  localparam int NO = 3;
  localparam int NP = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] pool_ack;
  logic [1:0] pool_cmd;
  logic       out_valid;
  logic [1:0] out_feature;
  logic [1:0] out_row;
  logic [1:0] out_col;
  logic       layer_done;
  logic       busy;

  pool_layer_controller #(
    .POOL_SIZE(2), .FMAP_SIZE(6), .OUT_SIZE(3), .TOTAL_FEATURE(4),
    .FEAT_WIDTH(2), .POS_WIDTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pool_ack(pool_ack),
    .pool_cmd(pool_cmd), .out_valid(out_valid), .out_feature(out_feature),
    .out_row(out_row), .out_col(out_col), .layer_done(layer_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int f;
    int r;
    int c;
  } tag_t;

  tag_t       tag_q[$];
  int         due_q[$];
  logic [1:0] cmd_q[$];
  logic [1:0] pend;
  int         wait_cnt;

  // Responder: answers each command after 0..2 cycles, sometimes with a
  // wrong-type ack while waiting. Returns the genuine ack it drove.
  task automatic resp_step(output logic [1:0] sent);
    logic [1:0] a;
    a = 2'b00;
    sent = 2'b00;
    if (pool_cmd != 2'b00) begin
      pend = pool_cmd;
      wait_cnt = int'($urandom_range(0, 2));
    end
    if (pend != 2'b00 && wait_cnt == 0) begin
      a = (pend == CMD_LOAD) ? ACK_LOAD : ACK_SHIFT;
      sent = a;
      pend = 2'b00;
    end else if (pend != 2'b00) begin
      if ($urandom_range(0, 3) == 0) a = (pend == CMD_LOAD) ? ACK_SHIFT : ACK_LOAD;
      wait_cnt--;
    end
    pool_ack = a;
  endtask

  // Runs a layer from a fresh enable edge; stops early after stop_after results.
  task automatic run_layer(input int stop_after, input string name);
    int results = 0;
    int loads = 0;
    int shifts = 0;
    int dones = 0;
    int n = 0;
    logic [1:0] sent;
    logic [5:0] exp_tag;
    bit ev;
    bit exp_done;
    tag_t t;
    tag_q.delete();
    due_q.delete();
    cmd_q.delete();
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < NO; r++) begin
        for (int l = 0; l < NP; l++) cmd_q.push_back(CMD_LOAD);
        for (int c = 0; c < NO; c++) begin
          cmd_q.push_back(CMD_SHIFT);
          t.f = f; t.r = r; t.c = c;
          tag_q.push_back(t);
        end
      end
    pend = 2'b00;
    wait_cnt = 0;
    pool_ack = 2'b00;
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    while (tag_q.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
      ev = (due_q.size() > 0) && (due_q[0] == cyc);
      exp_done = 1'b0;
      checks++;
      if (out_valid !== ev) begin
        errors++;
        $display("FAIL %s out_valid cyc=%0d got=%b exp=%b", name, cyc, out_valid, ev);
      end
      if (ev) begin
        t = tag_q.pop_front();
        void'(due_q.pop_front());
        exp_tag = {2'(t.f), 2'(t.r), 2'(t.c)};
        exp_done = (t.f == NF - 1) && (t.r == NO - 1) && (t.c == NO - 1);
        results++;
        checks++;
        if ({out_feature, out_row, out_col} !== exp_tag) begin
          errors++;
          $display("FAIL %s tag got={%0d,%0d,%0d} exp={%0d,%0d,%0d}", name,
                   out_feature, out_row, out_col, t.f, t.r, t.c);
        end
      end
      checks++;
      if (layer_done !== exp_done) begin
        errors++;
        $display("FAIL %s layer_done cyc=%0d got=%b exp=%b", name, cyc, layer_done, exp_done);
      end
      if (layer_done === 1'b1) dones++;
      if (stop_after != 0 && results == stop_after) begin
        pool_ack = 2'b00;
        return;
      end
      if (pool_cmd !== 2'b00) begin
        if (pool_cmd == CMD_LOAD) loads++;
        else if (pool_cmd == CMD_SHIFT) shifts++;
        checks++;
        if (cmd_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_cmd got=%b exp=none", name, pool_cmd);
        end else begin
          if (pool_cmd !== cmd_q[0]) begin
            errors++;
            $display("FAIL %s cmd_order got=%b exp=%b", name, pool_cmd, cmd_q[0]);
          end
          void'(cmd_q.pop_front());
        end
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_during_cmd got=%b exp=1", name, busy);
        end
      end
      resp_step(sent);
      if (sent == ACK_SHIFT) due_q.push_back(cyc + 3);
    end
    pool_ack = 2'b00;
    checks++;
    if (tag_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout remaining=%0d exp=0", name, tag_q.size());
    end
    if (stop_after == 0) begin
      checks++;
      if (loads != NF * NO * NP) begin
        errors++;
        $display("FAIL %s load_count got=%0d exp=%0d", name, loads, NF * NO * NP);
      end
      checks++;
      if (shifts != NF * NO * NO) begin
        errors++;
        $display("FAIL %s shift_count got=%0d exp=%0d", name, shifts, NF * NO * NO);
      end
      checks++;
      if (dones != 1) begin
        errors++;
        $display("FAIL %s layer_done_count got=%0d exp=1", name, dones);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || pool_cmd !== 2'b00) begin
        errors++;
        $display("FAIL %s after_layer busy=%b cmd=%b exp busy=0 cmd=00", name, busy, pool_cmd);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    pool_ack = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pool_cmd !== 2'b00) begin errors++; $display("FAIL reset pool_cmd got=%b exp=00", pool_cmd); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got=%b exp=0", out_valid); end
    checks++;
    if (layer_done !== 1'b0) begin errors++; $display("FAIL reset layer_done got=%b exp=0", layer_done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got=%b exp=0", busy); end
    checks++;
    if ({out_feature, out_row, out_col} !== 6'd0) begin
      errors++;
      $display("FAIL reset tags got={%0d,%0d,%0d} exp={0,0,0}", out_feature, out_row, out_col);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_acks();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pool_ack = 2'($urandom_range(0, 3));
      @(negedge clk);
      checks++;
      if (pool_cmd !== 2'b00 || busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_acks cmd=%b busy=%b valid=%b exp 00/0/0", pool_cmd, busy, out_valid);
      end
    end
    pool_ack = 2'b00;
  endtask

  task automatic test_nominal();
    run_layer(0, "nominal");
  endtask

  task automatic test_done_hold();
    for (int i = 0; i < 20; i++) begin
      pool_ack = 2'($urandom_range(0, 2));
      @(negedge clk);
      checks++;
      if (pool_cmd !== 2'b00) begin errors++; $display("FAIL done_hold cmd got=%b exp=00", pool_cmd); end
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL done_hold busy=%b valid=%b exp 0/0", busy, out_valid);
      end
    end
    pool_ack = 2'b00;
    run_layer(0, "relayer");
  endtask

  task automatic test_abort();
    run_layer(5, "pre_abort");
    enable = 1'b0;
    pool_ack = 2'b00;
    @(negedge clk);
    checks++;
    if (pool_cmd !== 2'b00 || out_valid !== 1'b0 || busy !== 1'b0 || layer_done !== 1'b0) begin
      errors++;
      $display("FAIL abort cmd=%b valid=%b busy=%b done=%b exp 00/0/0/0",
               pool_cmd, out_valid, busy, layer_done);
    end
    checks++;
    if ({out_feature, out_row, out_col} !== {2'd0, 2'd1, 2'd1}) begin
      errors++;
      $display("FAIL abort_tag_hold got={%0d,%0d,%0d} exp={0,1,1}", out_feature, out_row, out_col);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_flush out_valid got=%b exp=0", out_valid); end
    end
    run_layer(0, "restart");
  endtask

  task automatic test_reset_midflight();
    logic [1:0] sent;
    bit found = 1'b0;
    run_layer(4, "pre_reset");
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      resp_step(sent);
      if (sent == ACK_SHIFT) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL reset_mid no_shift_ack got=0 exp=1"); end
    @(negedge clk);
    pool_ack = 2'b00;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (pool_cmd !== 2'b00 || out_valid !== 1'b0 || busy !== 1'b0 || layer_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid ctrl cmd=%b valid=%b busy=%b done=%b exp all 0",
               pool_cmd, out_valid, busy, layer_done);
    end
    checks++;
    if ({out_feature, out_row, out_col} !== 6'd0) begin
      errors++;
      $display("FAIL reset_mid tags got={%0d,%0d,%0d} exp={0,0,0}", out_feature, out_row, out_col);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_flush out_valid got=%b exp=0", out_valid); end
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_acks();
    test_nominal();
    test_done_hold();
    test_abort();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
